// File: rtl/simd_write_checker.sv
// Store-trace checker: compares observed scalar/vector stores, in order, against a preloaded
// expected trace and reports pass/fail with timeout, failing index and failing lanes.
module simd_write_checker #(
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned LANES   = 16,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       exp_we,
    input  logic                       exp_vec,
    input  logic [ADDR_W-1:0]          exp_addr,
    input  logic [DATA_W-1:0]          exp_data,
    input  logic [LANES-1:0]           exp_mask,
    input  logic                       start,
    input  logic                       clear,
    input  logic                       obs_valid,
    input  logic                       obs_vec,
    input  logic [ADDR_W-1:0]          obs_addr,
    input  logic [DATA_W-1:0]          obs_data,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH)-1:0]   err_index,
    output logic [LANES-1:0]           err_lanes,
    output logic [$clog2(DEPTH+1)-1:0] match_count,
    output logic [$clog2(DEPTH+1)-1:0] exp_count,
    output logic                       overrun
);
    localparam int unsigned LW    = DATA_W / LANES;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_DATA    = 2'd1;
    localparam logic [1:0] ERR_ADDR    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    state_t state, state_next;

    logic              mem_vec  [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [LANES-1:0]  mem_mask [DEPTH];

    logic [CNT_W-1:0] exp_count_next, match_count_next, load_count, match_inc;
    logic [TO_W-1:0]  to_cnt, to_cnt_next;
    logic [1:0]       err_code_next;
    logic [IDX_W-1:0] err_index_next, ptr, wr_idx;
    logic [LANES-1:0] err_lanes_next, lane_diff, lane_bad;
    logic             overrun_next, mem_we;
    logic             cur_vec, kind_addr_bad, scalar_bad;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic [LANES-1:0]  cur_mask;

    // Trace storage: written in IDLE, read asynchronously at the match pointer
    assign wr_idx = exp_count[IDX_W-1:0];
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_vec[wr_idx]  <= exp_vec;
            mem_addr[wr_idx] <= exp_addr;
            mem_data[wr_idx] <= exp_data;
            mem_mask[wr_idx] <= exp_mask;
        end
    end

    assign ptr      = match_count[IDX_W-1:0];
    assign cur_vec  = mem_vec[ptr];
    assign cur_addr = mem_addr[ptr];
    assign cur_data = mem_data[ptr];
    assign cur_mask = mem_mask[ptr];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_diff[g] = obs_data[g*LW +: LW] != cur_data[g*LW +: LW];
    end

    assign kind_addr_bad = (obs_vec != cur_vec) || (obs_addr != cur_addr);
    assign scalar_bad    = obs_data[31:0] != cur_data[31:0];
    assign lane_bad      = lane_diff & cur_mask;
    assign match_inc     = match_count + CNT_W'(1);

    // Next-state and datapath update
    always_comb begin
        state_next       = state;
        exp_count_next   = exp_count;
        match_count_next = match_count;
        to_cnt_next      = to_cnt;
        err_code_next    = err_code;
        err_index_next   = err_index;
        err_lanes_next   = err_lanes;
        overrun_next     = overrun;
        load_count       = exp_count;
        mem_we           = 1'b0;

        if (clear) begin
            state_next       = IDLE;
            exp_count_next   = '0;
            match_count_next = '0;
            to_cnt_next      = '0;
            err_code_next    = ERR_NONE;
            err_index_next   = '0;
            err_lanes_next   = '0;
            overrun_next     = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (exp_we) begin
                        if (exp_count == CNT_W'(DEPTH)) begin
                            overrun_next = 1'b1;
                        end else begin
                            mem_we     = 1'b1;
                            load_count = exp_count + CNT_W'(1);
                        end
                    end
                    exp_count_next = load_count;
                    if (start) begin
                        state_next  = (load_count != '0) ? RUN : PASS;
                        to_cnt_next = '0;
                    end
                end
                RUN: begin
                    if (obs_valid && kind_addr_bad) begin
                        state_next     = FAIL;
                        err_code_next  = ERR_ADDR;
                        err_index_next = ptr;
                        err_lanes_next = '1;
                    end else if (obs_valid && !cur_vec && scalar_bad) begin
                        state_next     = FAIL;
                        err_code_next  = ERR_DATA;
                        err_index_next = ptr;
                        err_lanes_next = LANES'(1);
                    end else if (obs_valid && cur_vec && (lane_bad != '0)) begin
                        state_next     = FAIL;
                        err_code_next  = ERR_DATA;
                        err_index_next = ptr;
                        err_lanes_next = lane_bad;
                    end else if (obs_valid) begin
                        match_count_next = match_inc;
                        to_cnt_next      = '0;
                        if (match_inc == exp_count) state_next = PASS;
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        state_next     = FAIL;
                        err_code_next  = ERR_TIMEOUT;
                        err_index_next = ptr;
                        err_lanes_next = '0;
                    end else begin
                        to_cnt_next = to_cnt + TO_W'(1);
                    end
                end
                PASS: begin
                    if (obs_valid) overrun_next = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            exp_count   <= '0;
            match_count <= '0;
            to_cnt      <= '0;
            err_code    <= ERR_NONE;
            err_index   <= '0;
            err_lanes   <= '0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else begin
            state       <= state_next;
            exp_count   <= exp_count_next;
            match_count <= match_count_next;
            to_cnt      <= to_cnt_next;
            err_code    <= err_code_next;
            err_index   <= err_index_next;
            err_lanes   <= err_lanes_next;
            overrun     <= overrun_next;
            busy        <= state_next == RUN;
            done        <= (state_next == PASS) || (state_next == FAIL);
            pass        <= state_next == PASS;
        end
    end
endmodule
